pll_lock_supervisor: RTL

Sequencer for the GTP_PLL_E3 wrapper instance that generates the core clock. It powers up the PLL and drives its reset, then waits for lock and requires lock to stay stable before releasing the system reset. On lock loss or timeout it restarts the PLL, with a bounded number of retries. The block runs in the PLL reference-clock domain (50 MHz board clock). It sits between the board clock/reset pins and the PLL's `pll_rst`/`pll_pwd` inputs and `pll_lock` output.

---
 rtl/pll_lock_supervisor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// Power-up and reset sequencer for the core-clock PLL: drives pll_pwd/pll_rst,
// qualifies pll_lock and gates the downstream system reset.
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES         = 16,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT       = 65536,
    parameter int unsigned MAX_RETRIES        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       relock_req,
    input  logic       pll_lock,
    output logic       pll_rst,
    output logic       pll_pwd,
    output logic       sys_rst,
    output logic       locked,
    output logic       lost_lock,
    output logic       fail,
    output logic [3:0] retry_cnt
);
    localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
    localparam int unsigned CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]    RETRY_MAX    = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_OFF,
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [3:0]    retry_next;
    logic          lost_next;
    logic          restart;
    logic          lock_meta, lock_s;

    always_comb begin
        state_next = state;
        retry_next = retry_cnt;
        lost_next  = 1'b0;
        restart    = 1'b0;

        if (!en) begin
            state_next = S_OFF;
        end else if (relock_req || state == S_OFF) begin
            state_next = S_RESET;
            retry_next = '0;
            restart    = 1'b1;
        end else begin
            case (state)
                S_RESET: begin
                    if (cnt == RST_LAST) state_next = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_next = S_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry_cnt >= RETRY_MAX) begin
                            state_next = S_FAIL;
                        end else begin
                            retry_next = retry_cnt + 4'd1;
                            state_next = S_RESET;
                        end
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state_next = S_WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_next = S_RUN;
                        retry_next = '0;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_next = S_RESET;
                        lost_next  = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Counter only runs in timed states; relock restarts it even when RESET re-enters RESET.
        if (restart || state_next != state) begin
            cnt_next = '0;
        end else if (state == S_RESET || state == S_WAIT_LOCK || state == S_STABLE) begin
            cnt_next = cnt + 1'b1;
        end else begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            state     <= S_RESET;
            cnt       <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            pll_pwd   <= 1'b0;
            sys_rst   <= 1'b1;
            locked    <= 1'b0;
            lost_lock <= 1'b0;
            fail      <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
            state     <= state_next;
            cnt       <= cnt_next;
            retry_cnt <= retry_next;
            pll_pwd   <= (state_next == S_OFF);
            pll_rst   <= (state_next == S_OFF) || (state_next == S_RESET) || (state_next == S_FAIL);
            sys_rst   <= (state_next != S_RUN);
            locked    <= (state_next == S_RUN);
            fail      <= (state_next == S_FAIL);
            lost_lock <= lost_next;
        end
    end
endmodule
